// File: rtl/cpu_ctrl_checker.sv
// Runtime rule checker for the VeriRisc control unit: sticky per-rule flags,
// saturating violation count, first-failure snapshot and a ps sequence shadow.
module cpu_ctrl_checker #(
  parameter int          CNT_W     = 8,
  parameter int          CYC_W     = 16,
  parameter logic [9:0]  RULE_MASK = 10'h3FF,
  parameter bit          SEQ_CHECK = 1'b1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             chk_en,
  input  logic             err_clr,
  input  logic [2:0]       opcode,
  input  logic [2:0]       ps,
  input  logic             zero,
  input  logic             mem_rd,
  input  logic             load_ir,
  input  logic             halt,
  input  logic             inc_pc,
  input  logic             load_ac,
  input  logic             load_pc,
  input  logic             mem_wr,
  output logic [9:0]       err_flags,
  output logic             err_any,
  output logic [CNT_W-1:0] viol_cnt,
  output logic             first_vld,
  output logic [3:0]       first_rule,
  output logic [2:0]       first_ps,
  output logic [2:0]       first_op,
  output logic [CYC_W-1:0] first_cyc
);

  localparam logic [2:0] OP_HLT = 3'd0, OP_SKZ = 3'd1, OP_ADD = 3'd2, OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4, OP_LDA = 3'd5, OP_STO = 3'd6, OP_JMP = 3'd7;

  localparam logic [2:0] S_INST_LOAD = 3'd2, S_IDLE    = 3'd3, S_OP_ADDR = 3'd4;
  localparam logic [2:0] S_OP_FETCH  = 3'd5, S_ALU_OP  = 3'd6, S_STORE   = 3'd7;

  localparam logic [9:0] SEQ_MASK = {SEQ_CHECK, 9'h1FF};

  logic [9:0]       err_flags_q, err_flags_d;
  logic             err_any_q, err_any_d;
  logic [CNT_W-1:0] viol_cnt_q, viol_cnt_d;
  logic             first_vld_q, first_vld_d;
  logic [3:0]       first_rule_q, first_rule_d;
  logic [2:0]       first_ps_q, first_ps_d;
  logic [2:0]       first_op_q, first_op_d;
  logic [CYC_W-1:0] first_cyc_q, first_cyc_d;
  logic [CYC_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [2:0]       prev_ps_q, prev_ps_d;
  logic             prev_halt_q, prev_halt_d;
  logic             prev_vld_q, prev_vld_d;

  logic [9:0]       raw;
  logic [9:0]       v;
  logic [2:0]       ps_exp;
  logic             op_alu;
  logic [3:0]       rule_enc;
  logic [9:0]       flags_base;
  logic [CNT_W-1:0] cnt_base;
  logic             first_vld_base;

  // mem_rd is sampled alongside the other controls but no rule constrains it.
  logic mem_rd_unused;
  assign mem_rd_unused = mem_rd;

  always_comb begin
    op_alu  = (opcode == OP_ADD) || (opcode == OP_AND) ||
              (opcode == OP_XOR) || (opcode == OP_LDA);
    ps_exp  = prev_ps_q + 3'd1;
    raw     = '0;
    raw[0]  = op_alu && ((ps == S_ALU_OP) || (ps == S_STORE)) && !load_ac;
    raw[1]  = (opcode == OP_SKZ) && zero && (ps == S_ALU_OP) && !inc_pc;
    raw[2]  = (opcode == OP_JMP) && ((ps == S_ALU_OP) || (ps == S_STORE)) && !load_pc;
    raw[3]  = (opcode == OP_STO) && (ps == S_STORE) && !mem_wr;
    raw[4]  = load_pc && inc_pc && !((opcode == OP_JMP) && (ps == S_STORE));
    raw[5]  = (opcode == OP_JMP) && ((ps == S_OP_ADDR) || (ps == S_OP_FETCH)) && load_pc;
    raw[6]  = (opcode == OP_HLT) && (ps == S_OP_ADDR) && !halt;
    raw[7]  = ((ps == S_INST_LOAD) || (ps == S_IDLE)) && !load_ir;
    raw[8]  = ((ps == S_OP_ADDR) || (ps == S_ALU_OP)) && inc_pc && load_pc;
    // A repeated ps is only tolerated directly after a halting cycle.
    raw[9]  = prev_vld_q && (ps != ps_exp) && !(prev_halt_q && (ps == prev_ps_q));
    v       = raw & RULE_MASK & SEQ_MASK & {10{chk_en}};

    rule_enc = 4'd0;
    for (int r = 9; r >= 0; r--) begin
      if (v[r]) rule_enc = 4'(r);
    end
  end

  always_comb begin
    flags_base     = err_clr ? '0 : err_flags_q;
    cnt_base       = err_clr ? '0 : viol_cnt_q;
    first_vld_base = err_clr ? 1'b0 : first_vld_q;

    err_flags_d  = flags_base | v;
    err_any_d    = |err_flags_d;
    viol_cnt_d   = cnt_base;
    if ((|v) && (cnt_base != {CNT_W{1'b1}})) viol_cnt_d = cnt_base + CNT_W'(1);

    first_vld_d  = first_vld_base;
    first_rule_d = err_clr ? '0 : first_rule_q;
    first_ps_d   = err_clr ? '0 : first_ps_q;
    first_op_d   = err_clr ? '0 : first_op_q;
    first_cyc_d  = err_clr ? '0 : first_cyc_q;
    if (!first_vld_base && (|v)) begin
      first_vld_d  = 1'b1;
      first_rule_d = rule_enc;
      first_ps_d   = ps;
      first_op_d   = opcode;
      first_cyc_d  = cycle_cnt_q;
    end

    cycle_cnt_d = cycle_cnt_q + CYC_W'(1);
    prev_ps_d   = chk_en ? ps : prev_ps_q;
    prev_halt_d = chk_en ? halt : prev_halt_q;
    prev_vld_d  = chk_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_) begin
      err_flags_q  <= '0;
      err_any_q    <= 1'b0;
      viol_cnt_q   <= '0;
      first_vld_q  <= 1'b0;
      first_rule_q <= '0;
      first_ps_q   <= '0;
      first_op_q   <= '0;
      first_cyc_q  <= '0;
      cycle_cnt_q  <= '0;
      prev_ps_q    <= '0;
      prev_halt_q  <= 1'b0;
      prev_vld_q   <= 1'b0;
    end else begin
      err_flags_q  <= err_flags_d;
      err_any_q    <= err_any_d;
      viol_cnt_q   <= viol_cnt_d;
      first_vld_q  <= first_vld_d;
      first_rule_q <= first_rule_d;
      first_ps_q   <= first_ps_d;
      first_op_q   <= first_op_d;
      first_cyc_q  <= first_cyc_d;
      cycle_cnt_q  <= cycle_cnt_d;
      prev_ps_q    <= prev_ps_d;
      prev_halt_q  <= prev_halt_d;
      prev_vld_q   <= prev_vld_d;
    end
  end

  assign err_flags  = err_flags_q;
  assign err_any    = err_any_q;
  assign viol_cnt   = viol_cnt_q;
  assign first_vld  = first_vld_q;
  assign first_rule = first_rule_q;
  assign first_ps   = first_ps_q;
  assign first_op   = first_op_q;
  assign first_cyc  = first_cyc_q;

endmodule
